// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and nibble width.
package nibble_serial_add_ctrl_pkg;

    localparam int NSA_NIB_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Nibble index needs at least one bit, even for a single-nibble datapath.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder shared by every nibble step of the sequencer.
module nibble_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NSA_NIB_W-1:0] a,
    input  logic [NSA_NIB_W-1:0] b,
    input  logic                 ci,
    output logic [NSA_NIB_W-1:0] s,
    output logic                 co
);

    always_comb begin
        logic carry;
        s     = '0;
        carry = ci;
        for (int unsigned i = 0; i < NSA_NIB_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder with valid/ready on both sides, LSB nibble first.
// Optional subtract mode (sub port) is enabled by defining NSA_SUB_EN.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NSA_NIB_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NSA_NIB_W) != 0 || WIDTH < NSA_NIB_W) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 carry_q;
    logic [WIDTH-1:0]     b_eff;
    logic                 seed;
    logic [NSA_NIB_W-1:0] nib_s;
    logic                 nib_co;

    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    always_comb begin
        b_eff = b;
        seed  = cin;
`ifdef NSA_SUB_EN
        if (sub) begin
            b_eff = ~b;
            seed  = 1'b1;
        end
`endif
    end

    nibble_adder u_nibble_adder (
        .a  (a_q[NSA_NIB_W*idx +: NSA_NIB_W]),
        .b  (b_q[NSA_NIB_W*idx +: NSA_NIB_W]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= seed;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[NSA_NIB_W*idx +: NSA_NIB_W] <= nib_s;
                    carry_q <= nib_co;
                    if (idx == LAST_IDX) begin
                        cout  <= nib_co;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed scoreboard bench for nibble_serial_add_ctrl (sub-mode steps when NSA_SUB_EN is defined).
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
`ifdef NSA_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic cv, input logic sv);
        logic [WIDTH:0] t;
        exp_t e;
        if (sv) t = {1'b0, av} + {1'b0, ~bv} + {{WIDTH{1'b0}}, 1'b1};
        else    t = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accepting edge with the expectation queued.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv, input exp_t e);
        int n;
        a_i = av; b_i = bv; cin_i = cv; sub_i = sv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        tick();
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic recv(input string tag);
        int   n;
        exp_t e;
        wait_valid(n);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin : stim
        int   n;
        int   bad;
        exp_t e;
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        int   acc_t[$];
        int   k;
        int   got;
        int   cyc;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // 1: carry ripples through every nibble; latency is NIB cycles.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{sum: 16'h0000, cout: 1'b1});
        wait_valid(n);
        chk("t1_latency", 32'(n), 32'(NIB));
        recv("t1");

        // 2: handshake flags while busy.
        send(16'h1234, 16'h4321, 1'b1, 1'b0, exp_t'{sum: 16'h5556, cout: 1'b0});
        bad = 0;
        for (int i = 0; i < NIB; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        chk("t2_run_flags", 32'(bad), 32'd0);
        chk("t2_done_in_ready", 32'(in_ready), 32'd0);
        chk("t2_done_busy", 32'(busy), 32'd1);
        recv("t2");

        // 3: backpressure with ignored in_valid pulses.
        send(16'hBEEF, 16'h1111, 1'b0, 1'b0, model(16'hBEEF, 16'h1111, 1'b0, 1'b0));
        wait_valid(n);
        e = sb[0];
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            in_valid = (i % 2 == 0);
            tick();
            if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) bad++;
        end
        in_valid = 1'b0;
        chk("t3_stable", 32'(bad), 32'd0);
        recv("t3");
        tick(); tick(); tick();
        chk("t3_no_ghost", 32'(out_valid), 32'd0);

        // 4: reset during the second RUN cycle abandons the operation.
        send(16'h00F0, 16'h0F0F, 1'b0, 1'b0, model(16'h00F0, 16'h0F0F, 1'b0, 1'b0));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick(); tick(); tick(); tick(); tick();
        chk("t4_no_result", 32'(out_valid), 32'd0);
        send(16'd1, 16'd2, 1'b0, 1'b0, exp_t'{sum: 16'h0003, cout: 1'b0});
        recv("t4");

        // 5: back-to-back with in_valid and out_ready held high.
        va = '{16'hA5A5, 16'h8000, 16'h0F0F, 16'h7FFF};
        vb = '{16'h5A5B, 16'h8000, 16'hF0F0, 16'h0001};
        k = 0; got = 0; cyc = 0;
        a_i = va[0]; b_i = vb[0]; cin_i = 1'b0; sub_i = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 4 && cyc < 100) begin
            if (out_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("t5_sum", 32'(sum), 32'(e.sum));
                    chk("t5_cout", 32'(cout), 32'(e.cout));
                end
                got++;
            end
            acc = in_ready && in_valid;
            if (acc) begin
                sb.push_back(model(a_i, b_i, cin_i, 1'b0));
                acc_t.push_back(cyc);
            end
            tick();
            cyc++;
            if (acc) begin
                k++;
                if (k < 4) begin
                    a_i = va[k]; b_i = vb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("t5_results", 32'(got), 32'd4);
        chk("t5_accepts", 32'(acc_t.size()), 32'd4);
        for (int i = 1; i < acc_t.size(); i++)
            chk("t5_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'(NIB + 2));

`ifdef NSA_SUB_EN
        // 6: subtract mode.
        send(16'h0005, 16'h0007, 1'b0, 1'b1, exp_t'{sum: 16'hFFFE, cout: 1'b0});
        recv("t6_borrow");
        send(16'h0007, 16'h0005, 1'b0, 1'b1, exp_t'{sum: 16'h0002, cout: 1'b1});
        recv("t6_noborrow");
`endif

        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(1));
            send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
            recv("rand");
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
